// File: rtl/next_ptr_free_list_if.sv
// Alloc/free handshake bundle for the next-pointer free-list manager.
// Pool IDs are 6 bits wide to match the next_33x6 RAM.
interface next_ptr_free_list_if;
    logic       alloc_valid;
    logic [5:0] alloc_id;
    logic       alloc_ready;
    logic       free_valid;
    logic [5:0] free_id;
    logic       free_ready;

    // Consumer side: takes IDs and returns them.
    modport master (
        input  alloc_valid, alloc_id, free_ready,
        output alloc_ready, free_valid, free_id
    );

    // Free-list side: offers the list head and accepts returned IDs.
    modport slave (
        output alloc_valid, alloc_id, free_ready,
        input  alloc_ready, free_valid, free_id
    );
endinterface

// File: rtl/next_ptr_free_list.sv
// Free-list manager for 33 entry IDs (0..32).
// Free IDs form a singly linked list in the downstream next_33x6 RAM.
// After reset, an INIT pass writes next[i] = i+1 for i = 0..31, which
// builds the chain 0->1->...->32. The block then enters READY, where it
// pops from the head and appends at the tail.
module next_ptr_free_list (
    input  logic                       clock,
    input  logic                       reset_n,
    next_ptr_free_list_if.slave        pool,
    output logic [5:0]                 count,
    output logic                       init_done,
    output logic                       err,
    output logic [5:0]                 nxt_raddr,
    output logic                       nxt_ren,
    input  logic [5:0]                 nxt_rdata,
    output logic [5:0]                 nxt_waddr,
    output logic                       nxt_wen,
    output logic [5:0]                 nxt_wdata
);
    localparam logic [5:0] LAST_ID = 6'd32;
    localparam logic [5:0] POOL_SZ = 6'd33;

    typedef enum logic {INIT, READY} state_t;

    state_t     state;
    logic [4:0] icnt;
    logic [5:0] head;
    logic [5:0] tail;
    logic [5:0] cnt_q;

    logic rdy;
    logic alloc_fire;
    logic free_fire;
    logic one_left;
    logic tail_wr;

    assign rdy        = (state == READY);
    assign one_left   = (cnt_q == 6'd1);
    assign alloc_fire = pool.alloc_valid & pool.alloc_ready;
    assign free_fire  = pool.free_valid & pool.free_ready;

    // Link the returned ID behind the tail, unless it becomes the sole
    // element. That happens when the list is empty, or when the last
    // element leaves in the same cycle.
    assign tail_wr = free_fire & (cnt_q != 6'd0) & ~(alloc_fire & one_left);

    assign pool.alloc_valid = rdy & (cnt_q != 6'd0);
    assign pool.free_ready  = rdy & (cnt_q != POOL_SZ);
    assign pool.alloc_id    = head;
    assign init_done        = rdy;
    assign count            = cnt_q;

    // With one entry left, the head has no successor, so the read is suppressed.
    assign nxt_raddr = rdy ? head : 6'd0;
    assign nxt_ren   = rdy & (cnt_q >= 6'd2);

    // The RAM write port is shared by the INIT chain build and tail appends.
    // It is held quiet while reset_n is low, so every output stays at 0 in reset.
    always_comb begin
        nxt_wen   = 1'b0;
        nxt_waddr = 6'd0;
        nxt_wdata = 6'd0;
        if (!rdy) begin
            if (reset_n) begin
                nxt_wen   = 1'b1;
                nxt_waddr = {1'b0, icnt};
                nxt_wdata = {1'b0, icnt} + 6'd1;
            end
        end else if (tail_wr) begin
            nxt_wen   = 1'b1;
            nxt_waddr = tail;
            nxt_wdata = pool.free_id;
        end
    end

    // State machine and list registers: build the chain, then track head, tail and count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= INIT;
            icnt  <= 5'd0;
            head  <= 6'd0;
            tail  <= LAST_ID;
            cnt_q <= 6'd0;
            err   <= 1'b0;
        end else if (state == INIT) begin
            icnt <= icnt + 5'd1;
            if (icnt == 5'd31) begin
                state <= READY;
                cnt_q <= POOL_SZ;
            end
        end else begin
            if (free_fire && (pool.free_id > LAST_ID))
                err <= 1'b1;

            if (alloc_fire && free_fire) begin
                // The count is unchanged. The read returns pre-write data,
                // so a write to the old head is harmless.
                head <= one_left ? pool.free_id : nxt_rdata;
                tail <= pool.free_id;
            end else if (alloc_fire) begin
                // The head is left stale when the list drains, and is
                // reloaded on the next free.
                if (!one_left)
                    head <= nxt_rdata;
                cnt_q <= cnt_q - 6'd1;
            end else if (free_fire) begin
                if (cnt_q == 6'd0)
                    head <= pool.free_id;
                tail  <= pool.free_id;
                cnt_q <= cnt_q + 6'd1;
            end
        end
    end
endmodule
